// File: rtl/tri_pkg.sv
// tri_pkg: shared triangle-stage types, screen defaults and signed min/max helpers.
//   Items: DEF_SCREEN_W/DEF_SCREEN_H screen defaults, MW helper width,
//   state_t FSM encoding, min3/max3 over sign-extended coordinates.
package tri_pkg;
    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;
    // Callers sign-extend WIDTH-bit coordinates to MW bits before using min3/max3.
    localparam int MW = 64;

    typedef enum logic [2:0] {IDLE, EDGE, AREA, TEST, FWD, ACK, WAIT_LOW} state_t;

    function automatic logic signed [MW-1:0] min3(input logic signed [MW-1:0] a, b, c);
        logic signed [MW-1:0] m;
        m = a < b ? a : b;
        return m < c ? m : c;
    endfunction

    function automatic logic signed [MW-1:0] max3(input logic signed [MW-1:0] a, b, c);
        logic signed [MW-1:0] m;
        m = a > b ? a : b;
        return m > c ? m : c;
    endfunction
endpackage

// File: rtl/triangle_cull_if.sv
// triangle_cull_if: one triangle request channel (three vertices, colour, level request, done pulse).
//   master: drives vertices/colour/en, receives done; slave: the reverse.
interface triangle_cull_if #(
    parameter int WIDTH = 32,
    parameter int COLOUR_WIDTH = 3
);
    logic signed [WIDTH-1:0] ax, ay, bx, by, cx, cy;
    logic [COLOUR_WIDTH-1:0] colour;
    logic en;
    logic done;

    modport master (output ax, ay, bx, by, cx, cy, colour, en, input done);
    modport slave (input ax, ay, bx, by, cx, cy, colour, en, output done);
endinterface

// File: rtl/tri_area2.sv
// tri_area2: twice the signed triangle area, two-cycle registered latency.
//   clock; ax..cy: signed vertices (held stable by the caller);
//   area2: (b-a)x(c-a) cross product, full 2*WIDTH+3 bits, no truncation.
module tri_area2 #(
    parameter int WIDTH = 32
) (
    input  logic                      clock,
    input  logic signed [WIDTH-1:0]   ax, ay, bx, by, cx, cy,
    output logic signed [2*WIDTH+2:0] area2
);
    localparam int EW = WIDTH + 1;
    localparam int AW = 2 * WIDTH + 3;

    logic signed [EW-1:0] e1x, e1y, e2x, e2y;

    always_ff @(posedge clock) begin
        e1x <= EW'(bx) - EW'(ax);
        e1y <= EW'(by) - EW'(ay);
        e2x <= EW'(cx) - EW'(ax);
        e2y <= EW'(cy) - EW'(ay);
        area2 <= AW'(e1x) * AW'(e2y) - AW'(e1y) * AW'(e2x);
    end
endmodule

// File: rtl/triangle_cull.sv
// triangle_cull: drops degenerate, back-facing and off-screen triangles before rasterisation.
//   clock; reset: synchronous, active-low; cull_back: also cull area2<0;
//   up: triangle request from draw_triangle_pipe; dn: registered request to draw_triangle;
//   drawn_count/culled_count: saturating statistics.
module triangle_cull
    import tri_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int COLOUR_WIDTH = 3,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cull_back,
    triangle_cull_if.slave       up,
    triangle_cull_if.master      dn,
    output logic [CNT_WIDTH-1:0] drawn_count,
    output logic [CNT_WIDTH-1:0] culled_count
);
    localparam int AW = 2 * WIDTH + 3;
    localparam logic signed [MW-1:0] XLIM = MW'(SCREEN_W - 1);
    localparam logic signed [MW-1:0] YLIM = MW'(SCREEN_H - 1);

    state_t state, next;
    logic signed [AW-1:0] area2;
    logic signed [MW-1:0] xmin, xmax, ymin, ymax;
    logic [COLOUR_WIDTH-1:0] colour_q;
    logic cull;

    // Fed from the captured registers, which stay put until the next IDLE capture.
    tri_area2 #(.WIDTH(WIDTH)) u_area2 (
        .clock (clock),
        .ax    (dn.ax),
        .ay    (dn.ay),
        .bx    (dn.bx),
        .by    (dn.by),
        .cx    (dn.cx),
        .cy    (dn.cy),
        .area2 (area2)
    );

    assign dn.colour = colour_q;
    assign cull = area2 == '0 || (cull_back && area2[AW-1]) ||
                  xmax[MW-1] || xmin > XLIM || ymax[MW-1] || ymin > YLIM;

    always_comb begin
        next = state;
        dn.en = 1'b0;
        up.done = 1'b0;
        case (state)
            IDLE:     next = up.en ? EDGE : IDLE;
            EDGE:     next = AREA;
            AREA:     next = TEST;
            TEST:     next = cull ? ACK : FWD;
            FWD: begin
                dn.en = 1'b1;
                next = dn.done ? ACK : FWD;
            end
            ACK: begin
                up.done = 1'b1;
                next = WAIT_LOW;
            end
            WAIT_LOW: next = up.en ? WAIT_LOW : IDLE;
            default:  next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            dn.ax <= '0;
            dn.ay <= '0;
            dn.bx <= '0;
            dn.by <= '0;
            dn.cx <= '0;
            dn.cy <= '0;
            colour_q <= '0;
            drawn_count <= '0;
            culled_count <= '0;
        end else begin
            state <= next;
            if (state == IDLE && up.en) begin
                dn.ax <= up.ax;
                dn.ay <= up.ay;
                dn.bx <= up.bx;
                dn.by <= up.by;
                dn.cx <= up.cx;
                dn.cy <= up.cy;
                colour_q <= up.colour;
            end
            // Adding ~&count stops the counter at all-ones instead of wrapping.
            if (state == TEST) begin
                if (cull)
                    culled_count <= culled_count + CNT_WIDTH'(~&culled_count);
                else
                    drawn_count <= drawn_count + CNT_WIDTH'(~&drawn_count);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (state == AREA) begin
            xmin <= min3(MW'(dn.ax), MW'(dn.bx), MW'(dn.cx));
            xmax <= max3(MW'(dn.ax), MW'(dn.bx), MW'(dn.cx));
            ymin <= min3(MW'(dn.ay), MW'(dn.by), MW'(dn.cy));
            ymax <= max3(MW'(dn.ay), MW'(dn.by), MW'(dn.cy));
        end
    end
endmodule

// File: tb/tb_triangle_cull.sv
// tb_triangle_cull: scoreboard bench for triangle_cull with directed, hand-computed vectors.
module tb_triangle_cull;
    localparam int CW = 3;
    localparam int CMAX = (1 << CW) - 1;
    localparam int MN = 32'sh8000_0000;
    localparam int MX = 32'sh7fff_ffff;

    typedef struct {
        bit fwd;
        int ax, ay, bx, by, cx, cy;
        logic [2:0] col;
        int cap;
        int drawn, culled;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic cb;
    logic [CW-1:0] drawn, culled;
    int cyc = 0;
    int total = 0;
    int passed = 0;
    int dly = 3;
    int drawn_m = 0;
    int culled_m = 0;
    exp_t q[$];

    triangle_cull_if #(.WIDTH(32), .COLOUR_WIDTH(3)) up ();
    triangle_cull_if #(.WIDTH(32), .COLOUR_WIDTH(3)) dn ();

    triangle_cull #(.CNT_WIDTH(CW)) dut (
        .clock        (clk),
        .reset        (rst_n),
        .cull_back    (cb),
        .up           (up),
        .dn           (dn),
        .drawn_count  (drawn),
        .culled_count (culled)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic send(input int ax, ay, bx, by, cx, cy, input logic [2:0] col,
                        input bit cull_b, input bit fwd, input bit hold = 1'b0);
        exp_t e;
        int n;
        if (fwd) drawn_m = drawn_m == CMAX ? CMAX : drawn_m + 1;
        else culled_m = culled_m == CMAX ? CMAX : culled_m + 1;
        e = '{fwd, ax, ay, bx, by, cx, cy, col, cyc + 1, drawn_m, culled_m};
        q.push_back(e);
        up.ax = ax; up.ay = ay; up.bx = bx; up.by = by; up.cx = cx; up.cy = cy;
        up.colour = col;
        cb = cull_b;
        up.en = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!up.done && n < 300);
        if (!up.done) chk("in_done timeout", 0, 1);
        if (hold) repeat (10) @(negedge clk);
        up.en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Downstream rasteriser stand-in: pulses out_done dly cycles after out_en rises.
    initial begin
        dn.done = 1'b0;
        forever begin
            @(negedge clk);
            if (dn.en) begin
                repeat (dly - 1) @(negedge clk);
                dn.done = 1'b1;
                @(negedge clk);
                dn.done = 1'b0;
            end
        end
    end

    // Monitor: checks every out_en rise and every in_done pulse against the queue head.
    initial begin
        exp_t e;
        bit prev_en = 1'b0;
        bit seen = 1'b0;
        int done_edge = -1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                prev_en = 1'b0;
                seen = 1'b0;
            end else begin
                if (dn.en && dn.done) done_edge = cyc + 1;
                if (dn.en && !prev_en) begin
                    if (q.size() == 0) chk("unexpected out_en", 1, 0);
                    else begin
                        seen = 1'b1;
                        chk("out_en edge", cyc + 1, q[0].cap + 4);
                        chk("forward expected", 1, q[0].fwd);
                        chk("out_ax", dn.ax, q[0].ax);
                        chk("out_ay", dn.ay, q[0].ay);
                        chk("out_bx", dn.bx, q[0].bx);
                        chk("out_by", dn.by, q[0].by);
                        chk("out_cx", dn.cx, q[0].cx);
                        chk("out_cy", dn.cy, q[0].cy);
                        chk("out_colour", dn.colour, q[0].col);
                    end
                end
                prev_en = dn.en;
                if (up.done) begin
                    if (q.size() == 0) chk("unexpected in_done", 1, 0);
                    else begin
                        e = q.pop_front();
                        chk("forwarded", seen, e.fwd);
                        if (e.fwd) begin
                            chk("in_done after out_done", cyc, done_edge);
                            chk("out_ax held", dn.ax, e.ax);
                            chk("out_cy held", dn.cy, e.cy);
                        end else chk("cull in_done edge", cyc + 1, e.cap + 4);
                        chk("drawn_count", drawn, e.drawn);
                        chk("culled_count", culled, e.culled);
                    end
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0;
        cb = 1'b0;
        up.en = 1'b0;
        up.ax = 0; up.ay = 0; up.bx = 0; up.by = 0; up.cx = 0; up.cy = 0;
        up.colour = '0;
        repeat (3) @(negedge clk);
        chk("reset out_en", dn.en, 0);
        chk("reset in_done", up.done, 0);
        chk("reset drawn", drawn, 0);
        chk("reset culled", culled, 0);
        chk("reset out_ax", dn.ax, 0);
        chk("reset colour", dn.colour, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        dly = 20;
        send(10, 10, 50, 10, 10, 40, 3'd5, 1'b1, 1'b1);
        dly = 3;
        send(10, 10, 10, 40, 50, 10, 3'd1, 1'b1, 1'b0);
        send(10, 10, 10, 40, 50, 10, 3'd2, 1'b0, 1'b1);
        send(0, 0, 5, 5, 10, 10, 3'd3, 1'b0, 1'b0);
        send(200, 10, 220, 10, 200, 30, 3'd4, 1'b0, 1'b0);
        send(-20, -20, 100, -20, -20, 100, 3'd6, 1'b1, 1'b1);
        send(10, 130, 30, 130, 10, 150, 3'd7, 1'b0, 1'b0);
        send(-50, -50, -10, -50, -50, -10, 3'd1, 1'b0, 1'b0);
        send(159, 0, 200, 0, 159, 10, 3'd2, 1'b1, 1'b1);
        send(MN, MN, MX, MN, MN, MX, 3'd3, 1'b1, 1'b1);

        // Reset while the triangle is being forwarded; the late out_done must be ignored.
        dly = 50;
        q.push_back('{1'b1, 10, 10, 50, 10, 10, 40, 3'd5, cyc + 1, 0, 0});
        up.ax = 10; up.ay = 10; up.bx = 50; up.by = 10; up.cx = 10; up.cy = 40;
        up.colour = 3'd5;
        cb = 1'b1;
        up.en = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dn.en && n < 20);
        chk("out_en before reset", dn.en, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        up.en = 1'b0;
        @(negedge clk);
        chk("mid reset out_en", dn.en, 0);
        chk("mid reset in_done", up.done, 0);
        chk("mid reset drawn", drawn, 0);
        chk("mid reset culled", culled, 0);
        chk("mid reset out_ax", dn.ax, 0);
        rst_n = 1'b1;
        drawn_m = 0;
        culled_m = 0;
        repeat (60) @(negedge clk);
        chk("idle after stray out_done", dn.en, 0);
        dly = 3;
        send(10, 10, 50, 10, 10, 40, 3'd5, 1'b1, 1'b1);

        // Held in_en: each triangle must be captured once per low-to-high request.
        send(0, 0, 30, 0, 0, 30, 3'd1, 1'b1, 1'b1, 1'b1);
        send(0, 0, 0, 30, 30, 0, 3'd2, 1'b1, 1'b0, 1'b1);
        send(5, 5, 60, 5, 5, 60, 3'd3, 1'b1, 1'b1, 1'b1);

        for (int i = 0; i < 5; i++)
            send(i, 0, i + 20, 0, i, 20, 3'(i), 1'b1, 1'b1);
        chk("drawn saturated", drawn, CMAX);

        repeat (5) @(negedge clk);
        chk("scoreboard drained", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/triangle_cull.md
Name: triangle_cull

Overview:
- Screen-space triangle filter placed between draw_triangle_pipe and draw_triangle.
- Accepts one triangle (3 vertices plus colour) per handshake.
- Computes twice the signed area and tests the triangle against the screen rectangle.
- Forwards surviving triangles to the rasteriser and acknowledges culled ones immediately, so that degenerate, back-facing or off-screen triangles never start a screen_writer pass.

Parameters:
- WIDTH, 32, signed vertex coordinate width
- COLOUR_WIDTH, 3, colour width
- SCREEN_W, 160, screen width in pixels
- SCREEN_H, 120, screen height in pixels
- CNT_WIDTH, 16, width of the statistics counters

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low (0 = reset)
- cull_back  in  1  1 = cull triangles with area2<0
- in_ax, in_ay, in_bx, in_by, in_cx, in_cy  in  WIDTH each  signed upstream vertices
- in_colour  in  COLOUR_WIDTH  upstream colour
- in_en  in  1  upstream request (level); inputs are stable while high
- in_done  out  1  one-cycle acknowledge to upstream
- out_ax, out_ay, out_bx, out_by, out_cx, out_cy  out  WIDTH each  registered vertices to draw_triangle
- out_colour  out  COLOUR_WIDTH  registered colour
- out_en  out  1  request to draw_triangle (level)
- out_done  in  1  draw_triangle completion pulse
- drawn_count  out  CNT_WIDTH  triangles forwarded
- culled_count  out  CNT_WIDTH  triangles culled

Behaviour:
- Reset (reset=0 at a clock edge):
  - state=IDLE; in_done=0; out_en=0.
  - All out_* coordinates and colour = 0; both counters = 0.
  - Reset takes priority over everything, including in the middle of an operation. A pending out_done is dropped.
- FSM states: IDLE, EDGE, AREA, TEST, FWD, ACK, WAIT_LOW.
- IDLE: on in_en=1, latch all inputs into the out_* registers and go to EDGE (edge k).
- EDGE (k+1): register e1x=bx-ax, e1y=by-ay, e2x=cx-ax, e2y=cy-ay, each WIDTH+1 bits signed.
- AREA (k+2): register area2 = e1x*e2y - e1y*e2x, signed, 2*WIDTH+3 bits. No truncation.
- Also in AREA, register the vertex min/max for x and y.
- TEST (k+3): the triangle is culled if any of the following holds:
  - area2==0
  - cull_back=1 and area2<0
  - xmax<0 or xmin>SCREEN_W-1
  - ymax<0 or ymin>SCREEN_H-1
- TEST transitions:
  - Culled: go to ACK and increment culled_count.
  - Otherwise: go to FWD and increment drawn_count.
- Counter rule: both counters saturate at all-ones and never wrap.
- FWD:
  - out_en=1 from the cycle after TEST (k+4) until out_done is sampled high.
  - On that edge: out_en goes to 0 and the FSM moves to ACK.
  - out_done is ignored in every state other than FWD.
- ACK: in_done=1 for exactly one cycle, then WAIT_LOW.
- WAIT_LOW: stay until in_en=0, then go to IDLE. This prevents re-accepting the same triangle.
- Latency:
  - Culled triangle: in_done at k+4.
  - Forwarded triangle: out_en at k+4; in_done one cycle after out_done is sampled.
- Stability: out_* vertex and colour registers change only on an IDLE capture. They hold across FWD.
- Partial visibility: partially on-screen triangles are forwarded unclipped. Clipping is done in draw_triangle/screen_writer.
- cull_back is sampled in TEST only.

Decomposition:
- Shared package tri_pkg holds:
  - the state encoding localparams
  - the SCREEN_W/SCREEN_H defaults, also used by screen_writer
  - a function min3/max3 over signed WIDTH values
- One natural sub-module: tri_area2 (registered edge subtract + multiply-subtract, 2-cycle latency), reusable by a later depth/shading stage.

Test Plan:
- Triangle (10,10),(50,10),(10,40), cull_back=1, in_en held → area2=+1200.
  - out_en rises 4 cycles after capture with out_ax=10, out_by=10, out_cy=40.
  - Pulse out_done 20 cycles later → in_done one cycle later; drawn_count=1.
- Vertices B and C swapped (area2=-1200), cull_back=1 → out_en stays 0; in_done at k+4; culled_count=1.
- Same swapped triangle with cull_back=0 → forwarded; drawn_count increments.
- Collinear (0,0),(5,5),(10,10) → area2=0 → culled even with cull_back=0.
- Off-screen (200,10),(220,10),(200,30) with SCREEN_W=160 → culled.
- Partially visible (-20,-20),(100,-20),(-20,100) → forwarded unmodified.
- Reset during FWD (out_en=1):
  - Next edge: out_en=0, in_done=0, counters 0.
  - A following out_done pulse is ignored.
  - The next in_en triggers a fresh capture.
- Held in_en after in_done, with 3 triangles back-to-back → exactly one capture per in_en low→high cycle.
- Saturation: force drawn_count to 16'hFFFF, forward one more triangle → count remains 16'hFFFF.
